uart_rx_buffered: RTL

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_core.sv | 128 ++++++++++++
 rtl/uart_rx_buffered.sv | 91 +++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the buffered UART receiver.
// Holds the parity mode, the receiver FSM state encoding and the bit-period calculation.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial receiver: 2-flop synchronizer, frame FSM and deserializer.
// Emits a one-cycle push with the assembled frame after the stop bit sample.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int      CLK_HZ    = 100_000_000,
    parameter int      BAUD      = 19200,
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = PAR_EVEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic                 busy,
    output logic                 push,
    output logic [DATA_BITS-1:0] data,
    output logic                 perr,
    output logic                 ferr
);

    localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
    localparam int CNT_W      = $clog2(BIT_CYCLES);
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_t            state, state_d;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 cnt_clr;
    logic                 sample;
    logic                 rx_p0, rx_s, rx_p2;
    logic [DATA_BITS-1:0] shift_p1;
    logic                 perr_p1, ferr_p1, push_p1;

    // stage p0/p1: synchronizer, p2: previous rx_s for falling-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx_in;
            rx_s  <= rx_p0;
            rx_p2 <= rx_s;
        end
    end

    always_comb begin
        state_d = state;
        cnt_clr = 1'b0;
        sample  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_p2 && !rx_s) begin
                    state_d = ST_START;
                    cnt_clr = 1'b1;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    sample  = 1'b1;
                    cnt_clr = 1'b1;
                    if (bit_idx == IDX_LAST)
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    sample  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    sample  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            push_p1 <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_clr ? '0 : cnt + 1'b1;
            push_p1 <= (state == ST_STOP) && sample;
            if (state == ST_IDLE)
                bit_idx <= '0;
            else if (state == ST_DATA && sample)
                bit_idx <= bit_idx + 1'b1;
        end
    end

    // stage p1: frame assembly; held until the push drains it
    always_ff @(posedge clk) begin
        if (sample) begin
            case (state)
                ST_DATA:   shift_p1 <= {rx_s, shift_p1[DATA_BITS-1:1]};
                ST_PARITY: perr_p1  <= (^shift_p1) ^ rx_s ^ (PARITY == PAR_ODD);
                ST_STOP:   ferr_p1  <= ~rx_s;
                default:   ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign push = push_p1;
    assign data = shift_p1;
    assign perr = (PARITY == PAR_NONE) ? 1'b0 : perr_p1;
    assign ferr = ferr_p1;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver followed by a show-ahead FIFO of received frames.
// Outputs are forced to zero while reset is asserted.
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int      CLK_HZ    = 100_000_000,
    parameter int      BAUD      = 19200,
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = PAR_EVEN,
    parameter int      DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_in,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_perr,
    output logic                     rd_ferr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 2;

    logic                 core_busy, push, perr, ferr;
    logic [DATA_BITS-1:0] data;
    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 ovf;
    logic                 full, nonempty, pop, wr_en;
    logic [EW-1:0]        head;

    uart_rx_core #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx_in),
        .busy  (core_busy),
        .push  (push),
        .data  (data),
        .perr  (perr),
        .ferr  (ferr)
    );

    assign full     = (cnt == CW'(DEPTH));
    assign nonempty = (cnt != '0);
    assign pop      = nonempty && rd_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign wr_en    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(wr_en) - CW'(pop);
            if (push && full && !pop)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {ferr, perr, data};
    end

    assign head     = mem[rd_ptr];
    assign rd_valid = !reset && nonempty;
    assign rd_data  = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_perr  = rd_valid && head[DATA_BITS];
    assign rd_ferr  = rd_valid && head[DATA_BITS+1];
    assign count    = reset ? '0 : cnt;
    assign overflow = !reset && ovf;
    assign busy     = !reset && core_busy;

endmodule
